// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser: FSM states, header bytes,
// error codes and the running-checksum helper.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR2,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_t;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TO   = 2'b11;

  // Modulo-256 accumulate; the carry out is intentionally dropped.
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/frame_buf.sv
// Payload store: single synchronous write port, single combinational read port.
module frame_buf #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses 0x55 0xAA LEN payload CHK frames from a byte stream, checks the checksum,
// and replays the buffered payload on a valid/ready interface.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int MAX_LEN  = 16,
  parameter int TO_BYTES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  input  logic       pl_ready,
  output logic       pl_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       rx_drop
);

  localparam int TO_LIMIT = TO_BYTES * 10 * (CLK_FREQ / BAUD);
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam int IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t            state;
  logic [7:0]        len;
  logic [7:0]        sum;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  rd_addr;
  logic [7:0]        rd_data;
  logic [TO_W-1:0]   to_cnt;
  logic              counting;
  logic              timeout;
  logic              buf_we;

  assign counting = (state == ST_HDR2) || (state == ST_LEN) ||
                    (state == ST_PAYLOAD) || (state == ST_CHK);
  assign timeout  = counting && (to_cnt == TO_W'(TO_LIMIT - 1));
  assign buf_we   = (state == ST_PAYLOAD) && rx_valid && !timeout;

  // The read port looks one byte ahead so pl_data can be registered on each handshake;
  // outside DRAIN it points at byte 0, ready for the checksum-match cycle.
  assign rd_addr = (state == ST_DRAIN) ? rd_idx + IDX_W'(1) : '0;

  frame_buf #(
    .DEPTH  (MAX_LEN),
    .DATA_W (8),
    .ADDR_W (IDX_W)
  ) u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_addr (wr_idx),
    .wr_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      len       <= '0;
      sum       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      to_cnt    <= '0;
      pl_data   <= 8'h00;
      pl_valid  <= 1'b0;
      pl_last   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
      rx_drop   <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      rx_drop   <= 1'b0;

      if (!counting || rx_valid || timeout) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + TO_W'(1);

      // Timeout wins over a byte landing in the same cycle; that byte is dropped.
      if (timeout) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
        err_code  <= ERR_TO;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_valid && rx_data == HDR0) state <= ST_HDR2;
          end
          ST_HDR2: begin
            if (rx_valid) begin
              if (rx_data == HDR1)      state <= ST_LEN;
              else if (rx_data != HDR0) state <= ST_IDLE;
            end
          end
          ST_LEN: begin
            if (rx_valid) begin
              if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                frame_err <= 1'b1;
                err_code  <= ERR_LEN;
                state     <= ST_IDLE;
              end else begin
                len    <= rx_data;
                sum    <= rx_data;
                wr_idx <= '0;
                state  <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (rx_valid) begin
              sum    <= chk_add(sum, rx_data);
              wr_idx <= wr_idx + IDX_W'(1);
              if (8'(wr_idx) == len - 8'd1) state <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (rx_valid) begin
              if (rx_data == sum) begin
                frame_ok <= 1'b1;
                pl_valid <= 1'b1;
                pl_data  <= rd_data;
                pl_last  <= (len == 8'd1);
                rd_idx   <= '0;
                state    <= ST_DRAIN;
              end else begin
                frame_err <= 1'b1;
                err_code  <= ERR_CHK;
                state     <= ST_IDLE;
              end
            end
          end
          ST_DRAIN: begin
            rx_drop <= rx_valid;
            if (pl_valid && pl_ready) begin
              if (pl_last) begin
                pl_valid <= 1'b0;
                pl_last  <= 1'b0;
                state    <= ST_IDLE;
              end else begin
                rd_idx  <= rd_idx + IDX_W'(1);
                pl_data <= rd_data;
                pl_last <= (8'(rd_idx) + 8'd2 == len);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
